// File: rtl/xs3_pkg.sv
// Shared types and helpers for the bit-serial BCD to Excess-3 encoder.
package xs3_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  localparam logic [3:0] XS3_OFFSET = 4'd3;

  // A BCD digit is invalid when it is 10..15 (b3 set together with b2 or b1).
  function automatic logic is_bad_bcd(input logic [3:0] digit);
    return digit[3] & (digit[2] | digit[1]);
  endfunction

endpackage

// File: rtl/xs3_bit_adder.sv
// Mealy serial full adder that adds the constant Excess-3 offset one bit at a time.
module xs3_bit_adder
  import xs3_pkg::*;
(
  input  logic       data_bit,
  input  logic [1:0] pos,
  input  logic       carry_in,
  output logic       sum,
  output logic       carry_out
);

  logic addend;

  assign addend = XS3_OFFSET[pos];
  assign sum    = data_bit ^ addend ^ carry_in;

  // Carry out of the digit MSB is dropped so neighbouring digits stay independent.
  assign carry_out = (pos == 2'd3) ? 1'b0
                   : ((data_bit & addend) | (data_bit & carry_in) | (addend & carry_in));

endmodule

// File: rtl/bcd_to_excess3_serial.sv
// Bit-serial BCD to Excess-3 encoder: FSM, shift register, bit counter and
// valid/ready handshakes around the serial adder.
module bcd_to_excess3_serial
  import xs3_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] in_bcd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_xs3,
  output logic                out_err
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(W);

  state_t         state;
  state_t         state_next;
  logic [W-1:0]   sr;
  logic [CW-1:0]  cnt;
  logic           carry;
  logic           err;
  logic           sum;
  logic           carry_next;
  logic           last_bit;
  logic           any_bad;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign last_bit  = (cnt == CW'(W - 1));

  always_comb begin
    any_bad = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      any_bad = any_bad | is_bad_bcd(in_bcd[4*d +: 4]);
    end
  end

  xs3_bit_adder u_adder (
    .data_bit  (sr[0]),
    .pos       (cnt[1:0]),
    .carry_in  (carry),
    .sum       (sum),
    .carry_out (carry_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = CONV;
      CONV:    if (last_bit)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The counter is cleared on the last bit so it never needs to count past W-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr      <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      err     <= 1'b0;
      out_xs3 <= '0;
      out_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sr    <= in_bcd;
            cnt   <= '0;
            carry <= 1'b0;
            err   <= any_bad;
          end
        end
        CONV: begin
          sr    <= {sum, sr[W-1:1]};
          carry <= carry_next;
          cnt   <= last_bit ? '0 : cnt + CW'(1);
          if (last_bit) begin
            out_xs3 <= {sum, sr[W-1:1]};
            out_err <= err;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
